calc_unit_mc: RTL and testbench

//  Parametrised, handshaked successor to the execute-stage datapath of the multi-cycle CPU.

---
 rtl/calc_unit_mc.sv | 180 ++++++++++++++++++
 tb/tb_calc_unit_mc.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/calc_unit_mc.sv
// Execute-stage datapath: operand select, capture, single-cycle ALU ops
// or an iterative shift-add multiply, with a registered ALUOut and flags.
module calc_unit_mc #(
    parameter int WIDTH   = 16,
    parameter int CONST_A = 2,
    parameter int CONST_B = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_op,
    input  logic [1:0]       alu_src_a,
    input  logic [1:0]       alu_src_b,
    input  logic             pc_src,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] reg_a,
    input  logic [WIDTH-1:0] reg_b,
    input  logic [WIDTH-1:0] imm,
    output logic [WIDTH-1:0] alu_now,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             negative,
    output logic             out_valid,
    output logic             busy,
    output logic [WIDTH-1:0] pc_next
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRA = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [2:0]       op;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [SHW-1:0]   cnt;
    logic [SHW-1:0]   shamt;
    logic             last;
    logic             accept;
    logic             wb_en;
    logic [WIDTH-1:0] wb_val;

    assign accept = in_valid && in_ready;
    assign last   = (cnt == SHW'(WIDTH - 1));
    assign shamt  = op_b[SHW-1:0];

    always_comb begin
        src_a = '0;
        unique case (alu_src_a)
            2'd0: src_a = pc;
            2'd1: src_a = WIDTH'(CONST_A);
            2'd2: src_a = reg_a;
            2'd3: src_a = '0;
        endcase
    end

    always_comb begin
        src_b = '0;
        unique case (alu_src_b)
            2'd0: src_b = reg_b;
            2'd1: src_b = WIDTH'(CONST_B);
            2'd2: src_b = imm;
            2'd3: src_b = '0;
        endcase
    end

    // MUL reports 0 here; its product only ever appears on alu_out
    always_comb begin
        alu_now = '0;
        unique case (op)
            OP_ADD: alu_now = op_a + op_b;
            OP_SUB: alu_now = op_a + ~op_b + WIDTH'(1);
            OP_AND: alu_now = op_a & op_b;
            OP_OR:  alu_now = op_a | op_b;
            OP_XOR: alu_now = op_a ^ op_b;
            OP_SLL: alu_now = op_a << shamt;
            OP_SRA: alu_now = $unsigned($signed(op_a) >>> shamt);
            OP_MUL: alu_now = '0;
        endcase
    end

    assign acc_nxt = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (alu_op == OP_MUL) ? MUL : EXEC;
                end
            end
            EXEC: state_nxt = IDLE;
            MUL: begin
                if (last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state == MUL);
        wb_en    = (state == EXEC) || ((state == MUL) && last);
        wb_val   = (state == MUL) ? acc_nxt : alu_now;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_a      <= '0;
            op_b      <= '0;
            op       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            alu_out   <= '0;
            zero      <= 1'b1;
            negative  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= wb_en;
            if (accept) begin
                op_a   <= src_a;
                op_b   <= src_b;
                op     <= alu_op;
                acc    <= '0;
                mcand  <= src_a;
                mplier <= src_b;
                cnt    <= '0;
            end
            // one multiplier bit consumed per cycle, LSB first
            if (state == MUL) begin
                acc    <= acc_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + SHW'(1);
            end
            if (wb_en) begin
                alu_out  <= wb_val;
                zero     <= (wb_val == '0);
                negative <= wb_val[WIDTH-1];
            end
        end
    end

    assign pc_next = pc_src ? alu_out : alu_now;

endmodule

// File: tb/tb_calc_unit_mc.sv
// Directed self-checking bench for calc_unit_mc (16- and 32-bit instances).
module tb_calc_unit_mc;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, pc_src;
    logic [2:0]  alu_op;
    logic [1:0]  alu_src_a, alu_src_b;
    logic [15:0] pc, reg_a, reg_b, imm;
    logic [15:0] alu_now, alu_out, pc_next;
    logic        zero, negative, out_valid, busy;

    logic        w_in_valid, w_in_ready, w_pc_src;
    logic [2:0]  w_alu_op;
    logic [1:0]  w_alu_src_a, w_alu_src_b;
    logic [31:0] w_pc, w_reg_a, w_reg_b, w_imm;
    logic [31:0] w_alu_now, w_alu_out, w_pc_next;
    logic        w_zero, w_negative, w_out_valid, w_busy;

    int n_checks = 0;
    int n_errors = 0;

    calc_unit_mc #(.WIDTH(16)) u16 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_src(pc_src), .pc(pc), .reg_a(reg_a), .reg_b(reg_b), .imm(imm),
        .alu_now(alu_now), .alu_out(alu_out), .zero(zero),
        .negative(negative), .out_valid(out_valid), .busy(busy),
        .pc_next(pc_next)
    );

    calc_unit_mc #(.WIDTH(32)) u32 (
        .clk(clk), .reset(reset),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .alu_op(w_alu_op), .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b),
        .pc_src(w_pc_src), .pc(w_pc), .reg_a(w_reg_a), .reg_b(w_reg_b),
        .imm(w_imm),
        .alu_now(w_alu_now), .alu_out(w_alu_out), .zero(w_zero),
        .negative(w_negative), .out_valid(w_out_valid), .busy(w_busy),
        .pc_next(w_pc_next)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [1:0] sa, input logic [1:0] sb,
                          input logic [15:0] p, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] im,
                          input logic [15:0] exp, input logic ez,
                          input logic en);
        alu_op = o; alu_src_a = sa; alu_src_b = sb;
        pc = p; reg_a = a; reg_b = b; imm = im;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_now"}, alu_now, exp);
        chk({tag, "_rdy_lo"}, in_ready, 1'b0);
        tick();
        chk({tag, "_ov"}, out_valid, 1'b1);
        chk({tag, "_out"}, alu_out, exp);
        chk({tag, "_zero"}, zero, ez);
        chk({tag, "_neg"}, negative, en);
        chk({tag, "_rdy"}, in_ready, 1'b1);
    endtask

    task automatic run_mul(input string tag, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] exp);
        int lat, busy_cnt, bad_now;
        alu_op = 3'd7; alu_src_a = 2'd2; alu_src_b = 2'd0;
        reg_a = a; reg_b = b;
        in_valid = 1'b1;
        tick();
        // keep requesting a different op; none may be taken mid-MUL
        alu_op = 3'd0; reg_a = 16'h1111; reg_b = 16'h2222;
        lat = 0; busy_cnt = 0; bad_now = 0;
        while (!out_valid && lat < 40) begin
            if (busy && !in_ready) busy_cnt++;
            if (alu_now != 16'h0) bad_now++;
            tick();
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, "_lat"}, lat, 16);
        chk({tag, "_busy_cyc"}, busy_cnt, 16);
        chk({tag, "_no_reaccept"}, bad_now, 0);
        chk({tag, "_out"}, alu_out, exp);
        chk({tag, "_zero"}, zero, exp == 16'h0);
        chk({tag, "_rdy"}, in_ready, 1'b1);
        tick();
        chk({tag, "_ov_pulse"}, out_valid, 1'b0);
        chk({tag, "_hold"}, alu_out, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat, ov_cnt;
        in_valid = 0; pc_src = 0; alu_op = 0; alu_src_a = 0; alu_src_b = 0;
        pc = 0; reg_a = 0; reg_b = 0; imm = 0;
        w_in_valid = 0; w_pc_src = 0; w_alu_op = 0; w_alu_src_a = 0;
        w_alu_src_b = 0; w_pc = 0; w_reg_a = 0; w_reg_b = 0; w_imm = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", alu_out, 16'h0);
        chk("rst_zero", zero, 1'b1);
        chk("rst_neg", negative, 1'b0);
        chk("rst_ov", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rdy", in_ready, 1'b1);
        chk("rst_w_zero", w_zero, 1'b1);
        reset = 1'b0;
        tick();
        chk("idle_rdy", in_ready, 1'b1);
        chk("idle_ov", out_valid, 1'b0);

        run_op("add_pc", 3'd0, 2'd0, 2'd1, 16'h0100, 0, 0, 0,
               16'h0102, 1'b0, 1'b0);
        tick();
        chk("add_ov_pulse", out_valid, 1'b0);
        chk("add_hold", alu_out, 16'h0102);

        run_op("sub_eq", 3'd1, 2'd2, 2'd0, 0, 16'd5, 16'd5, 0,
               16'h0000, 1'b1, 1'b0);
        run_op("sub_neg", 3'd1, 2'd2, 2'd0, 0, 16'd3, 16'd7, 0,
               16'hFFFC, 1'b0, 1'b1);
        run_op("sra", 3'd6, 2'd2, 2'd2, 0, 16'h8000, 0, 16'd4,
               16'hF800, 1'b0, 1'b1);
        run_op("sll0", 3'd5, 2'd2, 2'd2, 0, 16'h0001, 0, 16'd16,
               16'h0001, 1'b0, 1'b0);
        run_op("sll3", 3'd5, 2'd2, 2'd2, 0, 16'h0081, 0, 16'd3,
               16'h0408, 1'b0, 1'b0);
        run_op("and", 3'd2, 2'd2, 2'd0, 0, 16'hF0F0, 16'h0FF0, 0,
               16'h00F0, 1'b0, 1'b0);
        run_op("or", 3'd3, 2'd2, 2'd0, 0, 16'hF0F0, 16'h0FF0, 0,
               16'hFFF0, 1'b0, 1'b1);
        run_op("xor", 3'd4, 2'd2, 2'd0, 0, 16'hF0F0, 16'h0FF0, 0,
               16'hFF00, 1'b0, 1'b1);
        run_op("consta", 3'd0, 2'd1, 2'd3, 0, 0, 0, 0,
               16'h0002, 1'b0, 1'b0);

        run_op("add_pc2", 3'd0, 2'd0, 2'd1, 16'h0100, 0, 0, 0,
               16'h0102, 1'b0, 1'b0);
        alu_op = 3'd2; alu_src_a = 2'd2; alu_src_b = 2'd0;
        reg_a = 16'hF0F0; reg_b = 16'h0FF0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        pc_src = 1'b1;
        #1;
        chk("pcnext_aluout", pc_next, 16'h0102);
        pc_src = 1'b0;
        #1;
        chk("pcnext_alunow", pc_next, 16'h00F0);
        tick();
        chk("pcnext_after", alu_out, 16'h00F0);

        run_mul("mul_a", 16'h0123, 16'h0010, 16'h1230);
        run_mul("mul_wrap", 16'hFFFF, 16'hFFFF, 16'h0001);
        run_mul("mul_z", 16'h1234, 16'h0000, 16'h0000);
        run_mul("mul_b", 16'h00FF, 16'h0101, 16'hFFFF);

        w_alu_op = 3'd0; w_alu_src_a = 2'd2; w_alu_src_b = 2'd1;
        w_reg_a = 32'h12345678;
        w_in_valid = 1'b1;
        tick();
        w_in_valid = 1'b0;
        tick();
        chk("w_add_ov", w_out_valid, 1'b1);
        chk("w_add_out", w_alu_out, 32'h1234567A);
        w_alu_op = 3'd7; w_alu_src_a = 2'd2; w_alu_src_b = 2'd0;
        w_reg_a = 32'h00010000; w_reg_b = 32'h00010000;
        w_in_valid = 1'b1;
        tick();
        w_in_valid = 1'b0;
        lat = 0;
        while (!w_out_valid && lat < 80) begin
            tick();
            lat++;
        end
        chk("w_mul_lat", lat, 32);
        chk("w_mul_out", w_alu_out, 32'h0);
        chk("w_mul_zero", w_zero, 1'b1);

        alu_op = 3'd7; alu_src_a = 2'd2; alu_src_b = 2'd0;
        reg_a = 16'h0123; reg_b = 16'h0010;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        chk("abort_busy_pre", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_rdy", in_ready, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_out", alu_out, 16'h0);
        chk("abort_zero", zero, 1'b1);
        chk("abort_ov", out_valid, 1'b0);
        chk("abort_now", alu_now, 16'h0);
        ov_cnt = 0;
        repeat (20) begin
            tick();
            if (out_valid) ov_cnt++;
        end
        chk("abort_no_ov", ov_cnt, 0);

        run_op("post_abort", 3'd0, 2'd2, 2'd2, 0, 16'h7FFF, 0, 16'h0001,
               16'h8000, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
